// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch front end.
package cpu_pkg;

   // Default architectural width of PCs and addresses.
   localparam int XLEN_DEFAULT = 32;

   // Instruction word width.
   localparam int INST_W = 32;

   // Byte distance between consecutive instruction words.
   localparam int WORD_STEP = 4;

   // Fetch controller states.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous clear. Pointers wrap modulo DEPTH,
// and DEPTH must be a power of two. Reads are combinational from the head slot.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_clr,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_wdata,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_rdata,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;

   // A pop is only honoured while there is something to pop.
   assign w_pop = i_pop && (r_count != '0);

   // Entry storage write port.
   // NOTE: the storage array is deliberately not reset. Stale contents are
   // unreachable because the count and pointers are reset, and leaving the
   // array out of reset allows it to map onto plain RAM or flops without a reset.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointer and occupancy bookkeeping; reset and clear take priority.
   // NOTE: state registers use non-blocking assignment so that every flop
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (i_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!i_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue. It issues sequential word fetches to a memory with
// one cycle of latency, buffers the responses with their PCs, and hands them
// to decode through a valid/ready pair. Each request reserves a queue slot
// (a credit) before it goes out, so a response always has room to land.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fetch_en,
   input  logic                         redirect_valid,
   input  logic [XLEN-1:0]              redirect_pc,
   output logic                         imem_req,
   output logic [XLEN-1:0]              imem_addr,
   input  logic [INST_W-1:0]            imem_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INST_W-1:0]            out_inst,
   output logic [XLEN-1:0]              out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int UW = CW + 1;
   localparam int EW = INST_W + XLEN;

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_pc;
   logic            r_inflight;
   logic            r_discard;

   logic            w_req;
   logic            w_pop;
   logic            w_push;
   logic            w_valid;
   logic [UW-1:0]   w_used;
   logic [CW-1:0]   w_count;
   logic [EW-1:0]   w_head;
   logic            w_unused_pc_bits;

   // The two low bits of a redirect target do not address a word.
   assign w_unused_pc_bits = ^redirect_pc[1:0];

   assign w_valid = (w_count != '0);
   assign w_pop   = w_valid && out_ready;

   // Slots already committed: stored entries plus a response on its way, minus
   // the entry leaving this cycle.
   assign w_used = UW'(w_count) + UW'(r_inflight) - UW'(w_pop);

   // A response is pushed unless a redirect made it stale.
   assign w_push = r_inflight && !r_discard;

   // Next state and request strobe.
   // NOTE: every signal assigned here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_req       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (fetch_en) begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (!fetch_en) begin
               w_state_nxt = ST_IDLE;
            end
            w_req = fetch_en && !redirect_valid && (w_used < UW'(DEPTH));
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Fetch PC, issued-PC tracking and in-flight/discard flags; a redirect
   // outranks any request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_discard  <= 1'b0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
         r_inflight <= 1'b0;
         r_discard  <= 1'b1;
      end else begin
         r_inflight <= w_req;
         r_discard  <= 1'b0;
         if (w_req) begin
            r_pc     <= r_pc + XLEN'(WORD_STEP);
            r_req_pc <= r_pc;
         end
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (redirect_valid),
      .i_push  (w_push),
      .i_wdata ({imem_rdata, r_req_pc}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   assign imem_req  = w_req;
   assign imem_addr = r_pc;
   assign out_valid = w_valid;
   assign out_inst  = w_valid ? w_head[EW-1 -: INST_W] : '0;
   assign out_pc    = w_valid ? w_head[XLEN-1:0] : '0;
   assign count     = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. The main instance (DEPTH=4, RESET_PC=0) is
// driven from a table of per-cycle vectors. A second instance (DEPTH=2,
// RESET_PC=0xFFFF_FFF8) covers address wrap and single-entry throughput.
// The memory model answers each request with addr ^ 0xA5A5_0000 one cycle later,
// and returns 0xDEAD_BEEF when no request was made.
module tb_fetch_queue;

   localparam logic [31:0] PAT  = 32'hA5A5_0000;
   localparam logic [31:0] IDLE_DATA = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance signals
   logic        rst = 1'b1;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  count;

   // Wrap instance signals
   logic        b_rst = 1'b1;
   logic        b_fetch_en = 1'b0;
   logic        b_imem_req;
   logic [31:0] b_imem_addr;
   logic [31:0] b_imem_rdata = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b0;
   logic [31:0] b_out_inst;
   logic [31:0] b_out_pc;
   logic [1:0]  b_count;

   fetch_queue #(
      .XLEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .count          (count)
   );

   fetch_queue #(
      .XLEN     (32),
      .DEPTH    (2),
      .RESET_PC (32'hFFFF_FFF8)
   ) u_wrap (
      .clk            (clk),
      .rst            (b_rst),
      .fetch_en       (b_fetch_en),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .imem_req       (b_imem_req),
      .imem_addr      (b_imem_addr),
      .imem_rdata     (b_imem_rdata),
      .out_valid      (b_out_valid),
      .out_ready      (b_out_ready),
      .out_inst       (b_out_inst),
      .out_pc         (b_out_pc),
      .count          (b_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   // Advance one clock. The memory model is updated here: the request seen
   // before the edge is answered just after it.
   task automatic tick();
      logic        a_rq;
      logic        b_rq;
      logic [31:0] a_ad;
      logic [31:0] b_ad;
      a_rq = imem_req;
      a_ad = imem_addr;
      b_rq = b_imem_req;
      b_ad = b_imem_addr;
      @(posedge clk);
      #1;
      imem_rdata   = a_rq ? (a_ad ^ PAT) : IDLE_DATA;
      b_imem_rdata = b_rq ? (b_ad ^ PAT) : IDLE_DATA;
   endtask

   typedef struct {
      logic        rst;
      logic        fen;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        chk;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic row(input logic r, input logic fe, input logic rd, input logic rv,
                      input logic [31:0] rpc, input logic chk, input logic e_req,
                      input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_pc, input logic [2:0] e_cnt);
      vec_t v;
      v.rst = r; v.fen = fe; v.rdy = rd; v.rv = rv; v.rpc = rpc;
      v.chk = chk; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pc = e_pc; v.e_cnt = e_cnt;
      vecs.push_back(v);
   endtask

   initial begin
      // ---- Reset, then sustained fetch with decode always ready ----
      //   rst fen rdy rv rpc         chk req addr          val pc            cnt
      row(1, 0, 0, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h0,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h4,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h8,     1, 32'h0,     1);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'hC,     1, 32'h4,     1);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h10,    1, 32'h8,     1);
      // ---- Decode stalled: queue fills to 4, requests stop, then drain ----
      row(1, 0, 0, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h4,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h8,     1, 32'h0,     1);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'hC,     1, 32'h0,     2);
      row(0, 1, 0, 0, 32'h0,     1, 0, 32'h10,    1, 32'h0,     3);
      row(0, 1, 0, 0, 32'h0,     1, 0, 32'h10,    1, 32'h0,     4);
      row(0, 1, 0, 0, 32'h0,     1, 0, 32'h10,    1, 32'h0,     4);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h10,    1, 32'h0,     4);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h14,    1, 32'h4,     3);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h18,    1, 32'h8,     3);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h1C,    1, 32'hC,     3);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h20,    1, 32'h10,    3);
      // ---- Redirect with 3 queued and 1 in flight ----
      row(1, 0, 0, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h4,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h8,     1, 32'h0,     1);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'hC,     1, 32'h0,     2);
      row(0, 1, 0, 1, 32'h103,   1, 0, 32'h10,    1, 32'h0,     3);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h100,   0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h104,   0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h108,   1, 32'h100,   1);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h10C,   1, 32'h104,   1);
      // ---- fetch_en dropped with 2 queued, 1 in flight; then resumed ----
      row(1, 0, 0, 0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h0,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h4,     0, 32'h0,     0);
      row(0, 1, 0, 0, 32'h0,     1, 1, 32'h8,     1, 32'h0,     1);
      row(0, 0, 0, 0, 32'h0,     1, 0, 32'hC,     1, 32'h0,     2);
      row(0, 0, 1, 0, 32'h0,     1, 0, 32'hC,     1, 32'h0,     3);
      row(0, 0, 1, 0, 32'h0,     1, 0, 32'hC,     1, 32'h4,     2);
      row(0, 0, 1, 0, 32'h0,     1, 0, 32'hC,     1, 32'h8,     1);
      row(0, 0, 1, 0, 32'h0,     1, 0, 32'hC,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 0, 32'hC,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'hC,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h10,    0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h14,    1, 32'hC,     1);
      // ---- Reset and redirect together during sustained fetch ----
      row(1, 1, 1, 1, 32'h200,   0, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 0, 32'h0,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h0,     0, 32'h0,     0);
      row(0, 1, 1, 0, 32'h0,     1, 1, 32'h4,     0, 32'h0,     0);

      foreach (vecs[i]) begin
         rst            = vecs[i].rst;
         fetch_en       = vecs[i].fen;
         out_ready      = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         #1;
         if (vecs[i].chk) begin
            check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            check($sformatf("row%0d out_pc", i), out_pc, vecs[i].e_pc);
            check($sformatf("row%0d out_inst", i), out_inst,
                  vecs[i].e_valid ? (vecs[i].e_pc ^ PAT) : 32'h0);
            check($sformatf("row%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
         end
         tick();
      end

      // ---- Address wrap from RESET_PC=0xFFFF_FFF8, DEPTH=2 throughput ----
      rst      = 1'b1;
      fetch_en = 1'b0;
      b_rst    = 1'b1;
      tick();
      b_rst       = 1'b0;
      b_fetch_en  = 1'b1;
      b_out_ready = 1'b1;
      #1;
      check("wrap c0 req", 32'(b_imem_req), 32'h0);
      check("wrap c0 addr", b_imem_addr, 32'hFFFF_FFF8);
      check("wrap c0 valid", 32'(b_out_valid), 32'h0);
      check("wrap c0 inst", b_out_inst, 32'h0);
      tick(); #1;
      check("wrap c1 req", 32'(b_imem_req), 32'h1);
      check("wrap c1 addr", b_imem_addr, 32'hFFFF_FFF8);
      tick(); #1;
      check("wrap c2 req", 32'(b_imem_req), 32'h1);
      check("wrap c2 addr", b_imem_addr, 32'hFFFF_FFFC);
      tick(); #1;
      check("wrap c3 req", 32'(b_imem_req), 32'h1);
      check("wrap c3 addr", b_imem_addr, 32'h0000_0000);
      check("wrap c3 pc", b_out_pc, 32'hFFFF_FFF8);
      check("wrap c3 inst", b_out_inst, 32'h5A5A_FFF8);
      tick(); #1;
      check("wrap c4 addr", b_imem_addr, 32'h0000_0004);
      check("wrap c4 pc", b_out_pc, 32'hFFFF_FFFC);
      check("wrap c4 count", 32'(b_count), 32'h1);
      tick(); #1;
      check("wrap c5 req", 32'(b_imem_req), 32'h1);
      check("wrap c5 pc", b_out_pc, 32'h0000_0000);
      check("wrap c5 inst", b_out_inst, 32'hA5A5_0000);
      tick(); #1;
      check("wrap c6 pc", b_out_pc, 32'h0000_0004);
      check("wrap c6 valid", 32'(b_out_valid), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
